output_sram_writer: RTL and testbench
=====================================

OUTPUT_SRAM_WRITER -- requirements
Module: output_sram_writer

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 4, number of requesting vertex-buffer banks.
REQ-002 SHALL have parameter BEATS_PER_NODE, default 8, max 16-bit beats stored per Node_id.
REQ-003 SHALL have parameter ADDR_W, default 10, output-SRAM address width.
REQ-004 SHALL have port clk  input  1  single clock, all state on posedge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port bank_pkt  input  NUM_BANKS x Bank_Req2Req_Output_SRAM  per-bank req, Grant_valid, sos, eos, data[15:0], Node_id.
REQ-007 SHALL have port req_grant  output  NUM_BANKS  one-hot grant pulse to banks.
REQ-008 SHALL have port sram_wen  output  1  output-SRAM write enable.
REQ-009 SHALL have port sram_addr  output  ADDR_W  write address.
REQ-010 SHALL have port sram_wdata  output  16  write data.
REQ-011 SHALL have port stream_done  output  1  one-cycle pulse on completion of a bank stream.
REQ-012 SHALL have port overflow_err  output  1  sticky flag, beat index exceeded BEATS_PER_NODE.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement states IDLE, GRANT, STREAM.
REQ-015 In IDLE, if any bank_pkt[i].req is sampled high, SHALL select one winner, register it, go to GRANT; req_grant[winner] SHALL be high for exactly the GRANT cycle.
REQ-016 In GRANT, the winner's beat with Grant_valid=1 SHALL be captured as beat 0; if that beat has eos=1, SHALL go to IDLE, else to STREAM.
REQ-017 In GRANT, a beat with Grant_valid=0 SHALL abort the grant, with no write, no stream_done, and a return to IDLE.
REQ-018 In STREAM, each cycle with winner Grant_valid=1 SHALL capture the next beat and increment the beat counter.
REQ-019 In STREAM, the stream SHALL end on a beat with eos=1, or on the first cycle with Grant_valid=0; either end SHALL return to IDLE.
REQ-020 A stream in which beat 0 is the only beat and carries eos=0 SHALL be accepted by REQ-019.
REQ-021 Each captured beat SHALL produce, exactly one cycle later: sram_wen=1, sram_wdata=data, sram_addr=(Node_id*BEATS_PER_NODE + beat_idx) truncated to ADDR_W.
REQ-022 Node_id SHALL be latched from beat 0 and held for the whole stream.
REQ-023 Beats with beat_idx >= BEATS_PER_NODE SHALL NOT be written, and SHALL set overflow_err, which stays set until reset.
REQ-024 stream_done SHALL pulse one cycle after the final write of a stream, and SHALL also pulse for a stream ended by Grant_valid=0 after at least one beat.
REQ-025 Requests from non-winning banks SHALL be ignored while busy; banks hold req, so no request is lost.
REQ-026 Minimum turnaround SHALL be: last beat in cycle t, IDLE in t+1, next req_grant in t+2.
REQ-027 Data/control fields of non-winning banks SHALL have no effect.

Reset
REQ-028 On reset assertion, independent of clk, state SHALL be IDLE.
REQ-029 On reset assertion, req_grant, sram_wen, sram_addr, sram_wdata, stream_done, overflow_err and busy SHALL all be 0.
REQ-030 On reset assertion, the beat counter, the latched Node_id and the round-robin pointer SHALL be 0.
REQ-031 Reset asserted mid-stream SHALL drop the pending write, and issue no stream_done.

Configuration
REQ-032 With OSW_ROUND_ROBIN_EN defined, arbitration SHALL be round-robin: search starts at (last winner + 1) mod NUM_BANKS, and the pointer updates on every grant.
REQ-033 Without OSW_ROUND_ROBIN_EN, arbitration SHALL be fixed priority, lowest bank index wins, with no pointer state.

Verification
REQ-034 Bank1 req, Node_id=3, 4 beats 0x0101..0x0404 with eos on beat 4 -> req_grant=0010 one cycle; sram_wen 4 cycles; addr 24,25,26,27; stream_done once.
REQ-035 Single-beat stream, eos=0 on beat 0, then Grant_valid=0 -> exactly one write at Node_id*8; stream_done pulses; state IDLE.
REQ-036 Banks 0 and 2 req together, twice in sequence -> RR build: grants 0 then 2; fixed-priority build: grants 0 then 0 again if bank0 re-requests.
REQ-037 Node_id=1, 10 beats -> 8 writes at addr 8..15; overflow_err=1 and held until reset.
REQ-038 Reset asserted during beat 2 of a stream -> all outputs 0 immediately; no further writes; next req granted normally.
REQ-039 Grant with Grant_valid=0 in GRANT -> no write, no stream_done, IDLE next cycle.

Source files
------------

// File: rtl/output_sram_writer.sv
// output_sram_writer: arbitrates between NUM_BANKS vertex-buffer banks and
// streams the winner's 16-bit beats into the output SRAM. Each beat lands at
// Node_id*BEATS_PER_NODE + beat_idx.
// Build option: define OSW_ROUND_ROBIN_EN for round-robin arbitration.
// Without it, arbitration is fixed priority and the lowest bank index wins.
//
// Handshake (one rule for every bank):
//   - A bank raises req and holds it until it sees its req_grant bit.
//   - req_grant is a one-cycle pulse, high during the GRANT cycle.
//   - From that cycle onward, each cycle in which the winner drives
//     grant_valid=1 transfers exactly one beat. There is no backpressure.
//   - The stream ends on a beat with eos=1, or on the first cycle with
//     grant_valid=0. A grant_valid=0 seen in the GRANT cycle aborts the grant.

package output_sram_writer_pkg;
    localparam int NODE_ID_W = 8;

    typedef struct packed {
        logic                 req;
        logic                 grant_valid;
        logic                 sos;
        logic                 eos;
        logic [15:0]          data;
        logic [NODE_ID_W-1:0] node_id;
    } bank_req2req_output_sram_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_STREAM = 2'd2
    } osw_state_t;
endpackage

module output_sram_writer
    import output_sram_writer_pkg::*;
#(
    parameter int NUM_BANKS      = 4,
    parameter int BEATS_PER_NODE = 8,
    parameter int ADDR_W         = 10
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  bank_req2req_output_sram_t [NUM_BANKS-1:0]  bank_pkt,
    output logic [NUM_BANKS-1:0]                       req_grant,
    output logic                                       sram_wen,
    output logic [ADDR_W-1:0]                          sram_addr,
    output logic [15:0]                                sram_wdata,
    output logic                                       stream_done,
    output logic                                       overflow_err,
    output logic                                       busy,
    output logic [1:0]                                 fsm_state
);

    localparam int IDX_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int CNT_W = $clog2(BEATS_PER_NODE + 1);
    localparam logic [CNT_W-1:0] BEAT_LIMIT = CNT_W'(BEATS_PER_NODE);

    osw_state_t                state;
    logic [IDX_W-1:0]          winner;
    logic [CNT_W-1:0]          beat_cnt;
    logic [NODE_ID_W-1:0]      node_q;
    logic                      done_pend;

    bank_req2req_output_sram_t win_pkt;
    logic                      arb_found;
    logic [IDX_W-1:0]          arb_idx;
    logic [IDX_W-1:0]          cand;

    logic                      cap_fire;
    logic [NODE_ID_W-1:0]      cap_node;
    logic [CNT_W-1:0]          cap_idx;
    logic                      cap_in_range;
    logic [ADDR_W-1:0]         cap_addr;

    // The request and start-of-stream flags of the winner carry no information
    // once the grant is issued.
    logic                      win_unused;
    assign win_unused = win_pkt.req ^ win_pkt.sos;

    assign fsm_state = state;

`ifdef OSW_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] rr_next;

    // Round-robin pick: the search starts at rr_ptr, which holds last winner + 1.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NUM_BANKS);
            if (!arb_found && bank_pkt[cand].req) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
        rr_next = IDX_W'((int'(arb_idx) + 1) % NUM_BANKS);
    end

    // Advance the search start past the bank that was just granted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (state == ST_IDLE && arb_found) begin
            rr_ptr <= rr_next;
        end
    end
`else
    // Fixed-priority pick: the lowest requesting bank index wins.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            cand = IDX_W'(k);
            if (!arb_found && bank_pkt[cand].req) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end
`endif

    // Only the registered winner's fields are ever looked at.
    always_comb begin
        win_pkt = bank_pkt[winner];
    end

    // Beat capture: beat 0 takes Node_id straight from the packet, later beats
    // use the latched copy. Address arithmetic wraps at ADDR_W bits.
    always_comb begin
        cap_fire     = ((state == ST_GRANT) || (state == ST_STREAM)) && win_pkt.grant_valid;
        cap_node     = (state == ST_GRANT) ? win_pkt.node_id : node_q;
        cap_idx      = (state == ST_GRANT) ? '0 : beat_cnt;
        cap_in_range = (cap_idx < BEAT_LIMIT);
        cap_addr     = ADDR_W'(cap_node) * ADDR_W'(BEATS_PER_NODE) + ADDR_W'(cap_idx);
    end

    // Control FSM with registered outputs. A write appears one cycle after its
    // beat is captured. stream_done follows the final write by one more cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            winner       <= '0;
            beat_cnt     <= '0;
            node_q       <= '0;
            done_pend    <= 1'b0;
            req_grant    <= '0;
            sram_wen     <= 1'b0;
            sram_addr    <= '0;
            sram_wdata   <= '0;
            stream_done  <= 1'b0;
            overflow_err <= 1'b0;
            busy         <= 1'b0;
        end else begin
            req_grant   <= '0;
            sram_wen    <= 1'b0;
            stream_done <= done_pend;
            done_pend   <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (arb_found) begin
                        winner    <= arb_idx;
                        req_grant <= NUM_BANKS'(1) << arb_idx;
                        state     <= ST_GRANT;
                        busy      <= 1'b1;
                    end
                end

                ST_GRANT: begin
                    if (win_pkt.grant_valid) begin
                        node_q   <= win_pkt.node_id;
                        beat_cnt <= CNT_W'(1);
                        if (win_pkt.eos) begin
                            state     <= ST_IDLE;
                            busy      <= 1'b0;
                            done_pend <= 1'b1;
                        end else begin
                            state <= ST_STREAM;
                        end
                    end else begin
                        // Winner backed out: nothing captured, nothing to report.
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end

                ST_STREAM: begin
                    if (win_pkt.grant_valid) begin
                        // The counter saturates so long streams stay out of range.
                        if (beat_cnt < BEAT_LIMIT) begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                        if (win_pkt.eos) begin
                            state     <= ST_IDLE;
                            busy      <= 1'b0;
                            done_pend <= 1'b1;
                        end
                    end else begin
                        // The last write is already on the port this cycle.
                        state       <= ST_IDLE;
                        busy        <= 1'b0;
                        stream_done <= 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase

            if (cap_fire) begin
                if (cap_in_range) begin
                    sram_wen   <= 1'b1;
                    sram_wdata <= win_pkt.data;
                    sram_addr  <= cap_addr;
                end else begin
                    overflow_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_output_sram_writer.sv
// Directed bench for output_sram_writer.
// A negedge monitor logs grants, writes and done pulses, together with their cycle numbers.
// Each test states its expected writes by hand and then compares them with the log.
module tb_output_sram_writer;
  import output_sram_writer_pkg::*;

  localparam int NB = 4;
  localparam int BPN = 8;
  localparam int AW = 10;

  typedef logic [1:0] bank_idx_t;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bank_req2req_output_sram_t [NB-1:0] bank_pkt;
  logic [NB-1:0] req_grant;
  logic          sram_wen;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_wdata;
  logic          stream_done;
  logic          overflow_err;
  logic          busy;
  logic [1:0]    fsm_state;

  output_sram_writer #(
    .NUM_BANKS(NB),
    .BEATS_PER_NODE(BPN),
    .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bank_pkt(bank_pkt),
    .req_grant(req_grant),
    .sram_wen(sram_wen),
    .sram_addr(sram_addr),
    .sram_wdata(sram_wdata),
    .stream_done(stream_done),
    .overflow_err(overflow_err),
    .busy(busy),
    .fsm_state(fsm_state)
  );

  // scoreboard state
  int n_total = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [AW+15:0] exp_q[$];
  logic [AW+15:0] got_q[$];
  int wcyc_q[$];
  int done_q[$];
  int gcyc_q[$];
  logic [NB-1:0] grant_q[$];

  // monitor: sample outputs half a cycle away from the active edge
  always @(negedge clk) begin
    cyc++;
    if (req_grant != '0) begin
      grant_q.push_back(req_grant);
      gcyc_q.push_back(cyc);
    end
    if (sram_wen) begin
      got_q.push_back({sram_addr, sram_wdata});
      wcyc_q.push_back(cyc);
    end
    if (stream_done) done_q.push_back(cyc);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    exp_q.delete();
    got_q.delete();
    wcyc_q.delete();
    done_q.delete();
    gcyc_q.delete();
    grant_q.delete();
  endtask

  function automatic logic [15:0] beat_data(input int k);
    return {8'(k + 1), 8'(k + 1)};
  endfunction

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge where a grant is visible.
  task automatic wait_grant(input string tag, output int gb);
    gb = -1;
    for (int i = 0; i < 20 && gb < 0; i++) begin
      if (req_grant != '0) begin
        for (int b = 0; b < NB; b++) if (req_grant[b]) gb = b;
      end else begin
        @(negedge clk);
      end
    end
    if (gb < 0) begin
      check_eq({tag, "_grant_timeout"}, 32'(req_grant != '0), 32'd1);
      gb = 0;
    end
  endtask

  task automatic drive_beat(input bank_idx_t b, input int node, input logic [15:0] d, input logic eos);
    bank_pkt[b].grant_valid = 1'b1;
    bank_pkt[b].eos = eos;
    bank_pkt[b].data = d;
    bank_pkt[b].node_id = 8'(node);
  endtask

  task automatic idle_bank(input bank_idx_t b);
    bank_pkt[b].grant_valid = 1'b0;
    bank_pkt[b].eos = 1'b0;
    bank_pkt[b].data = '0;
  endtask

  // Entered at the grant negedge; drives n beats and then drops grant_valid.
  task automatic send_stream(input bank_idx_t b, input int node, input int n,
                             input logic eos_last, input logic keep_req);
    if (!keep_req) bank_pkt[b].req = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      drive_beat(b, node, beat_data(k), eos_last && (k == n - 1));
    end
    @(negedge clk);
    idle_bank(b);
  endtask

  task automatic compare_writes(input string tag);
    check_eq({tag, "_nwrites"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_eq({tag, "_write"}, 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: sim time limit reached, total=%0d", n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    int gb;
    int gb2;
    int gb3;

    reset = 1'b1;
    bank_pkt = '0;
    settle(2);

    // reset state
    check_eq("rst_grant", 32'(req_grant), 32'd0);
    check_eq("rst_wen", 32'(sram_wen), 32'd0);
    check_eq("rst_addr", 32'(sram_addr), 32'd0);
    check_eq("rst_wdata", 32'(sram_wdata), 32'd0);
    check_eq("rst_done", 32'(stream_done), 32'd0);
    check_eq("rst_ovf", 32'(overflow_err), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_state", 32'(fsm_state), 32'd0);
    reset = 1'b0;
    settle(2);

    // bank1, node 3, four beats, eos on the fourth
    clear_logs();
    bank_pkt[1].req = 1'b1;
    wait_grant("t2", gb);
    check_eq("t2_grant_vec", 32'(req_grant), 32'b0010);
    check_eq("t2_busy", 32'(busy), 32'd1);
    send_stream(2'd1, 3, 4, 1'b1, 1'b0);
    settle(4);
    exp_q.push_back({10'd24, 16'h0101});
    exp_q.push_back({10'd25, 16'h0202});
    exp_q.push_back({10'd26, 16'h0303});
    exp_q.push_back({10'd27, 16'h0404});
    compare_writes("t2");
    check_eq("t2_grant_cycles", 32'(grant_q.size()), 32'd1);
    check_eq("t2_ndone", 32'(done_q.size()), 32'd1);
    if (wcyc_q.size() == 4 && gcyc_q.size() == 1 && done_q.size() == 1) begin
      check_eq("t2_first_write_lat", 32'(wcyc_q[0] - gcyc_q[0]), 32'd1);
      check_eq("t2_done_lat", 32'(done_q[0] - wcyc_q[3]), 32'd1);
    end
    check_eq("t2_idle_busy", 32'(busy), 32'd0);

    // single beat with eos=0, ended by grant_valid=0
    clear_logs();
    bank_pkt[0].req = 1'b1;
    wait_grant("t3", gb);
    check_eq("t3_grant_vec", 32'(req_grant), 32'b0001);
    send_stream(2'd0, 5, 1, 1'b0, 1'b0);
    settle(3);
    exp_q.push_back({10'd40, 16'h0101});
    compare_writes("t3");
    check_eq("t3_ndone", 32'(done_q.size()), 32'd1);
    if (wcyc_q.size() == 1 && done_q.size() == 1)
      check_eq("t3_done_lat", 32'(done_q[0] - wcyc_q[0]), 32'd1);
    check_eq("t3_state", 32'(fsm_state), 32'd0);
    check_eq("t3_busy", 32'(busy), 32'd0);

    // grant aborted by grant_valid=0 in GRANT
    clear_logs();
    bank_pkt[3].req = 1'b1;
    wait_grant("t4", gb);
    check_eq("t4_state_grant", 32'(fsm_state), 32'd1);
    bank_pkt[3].req = 1'b0;
    @(negedge clk);
    check_eq("t4_state_idle", 32'(fsm_state), 32'd0);
    check_eq("t4_busy", 32'(busy), 32'd0);
    check_eq("t4_wen", 32'(sram_wen), 32'd0);
    settle(3);
    check_eq("t4_nwrites", 32'(got_q.size()), 32'd0);
    check_eq("t4_ndone", 32'(done_q.size()), 32'd0);

    // banks 0 and 2 contend; bank0 re-requests after its first stream
    clear_logs();
    bank_pkt[0].req = 1'b1;
    bank_pkt[2].req = 1'b1;
    wait_grant("t5a", gb);
    check_eq("t5_first", 32'(gb), 32'd0);
    send_stream(bank_idx_t'(gb), 2, 1, 1'b1, 1'b1);
    wait_grant("t5b", gb2);
`ifdef OSW_ROUND_ROBIN_EN
    check_eq("t5_second", 32'(gb2), 32'd2);
`else
    check_eq("t5_second", 32'(gb2), 32'd0);
`endif
    if (gcyc_q.size() == 2)
      check_eq("t5_turnaround", 32'(gcyc_q[1] - gcyc_q[0]), 32'd2);
    send_stream(bank_idx_t'(gb2), 2, 1, 1'b1, 1'b0);
    wait_grant("t5c", gb3);
`ifdef OSW_ROUND_ROBIN_EN
    check_eq("t5_third", 32'(gb3), 32'd0);
`else
    check_eq("t5_third", 32'(gb3), 32'd2);
`endif
    send_stream(bank_idx_t'(gb3), 2, 1, 1'b1, 1'b0);
    settle(4);
    repeat (3) exp_q.push_back({10'd16, 16'h0101});
    compare_writes("t5");
    check_eq("t5_ndone", 32'(done_q.size()), 32'd3);

    // overflow: node 1, ten beats, only eight written
    clear_logs();
    check_eq("t6_ovf_pre", 32'(overflow_err), 32'd0);
    bank_pkt[1].req = 1'b1;
    wait_grant("t6", gb);
    send_stream(2'd1, 1, 10, 1'b1, 1'b0);
    settle(4);
    for (int k = 0; k < 8; k++) exp_q.push_back({10'(8 + k), beat_data(k)});
    compare_writes("t6");
    check_eq("t6_ovf", 32'(overflow_err), 32'd1);
    check_eq("t6_ndone", 32'(done_q.size()), 32'd1);
    settle(10);
    check_eq("t6_ovf_held", 32'(overflow_err), 32'd1);

    // reset in the middle of a stream, during beat 2
    clear_logs();
    bank_pkt[2].req = 1'b1;
    wait_grant("t7", gb);
    bank_pkt[2].req = 1'b0;
    drive_beat(2'd2, 4, beat_data(0), 1'b0);
    @(negedge clk);
    drive_beat(2'd2, 4, beat_data(1), 1'b0);
    @(negedge clk);
    drive_beat(2'd2, 4, beat_data(2), 1'b0);
    check_eq("t7_wen_pre", 32'(sram_wen), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("t7_wen", 32'(sram_wen), 32'd0);
    check_eq("t7_addr", 32'(sram_addr), 32'd0);
    check_eq("t7_wdata", 32'(sram_wdata), 32'd0);
    check_eq("t7_busy", 32'(busy), 32'd0);
    check_eq("t7_ovf", 32'(overflow_err), 32'd0);
    check_eq("t7_done", 32'(stream_done), 32'd0);
    check_eq("t7_grant", 32'(req_grant), 32'd0);
    check_eq("t7_state", 32'(fsm_state), 32'd0);
    idle_bank(2'd2);
    @(negedge clk);
    clear_logs();
    settle(2);
    reset = 1'b0;
    settle(3);
    check_eq("t7_nwrites_after", 32'(got_q.size()), 32'd0);
    check_eq("t7_ndone_after", 32'(done_q.size()), 32'd0);

    // normal grant after reset: bank3, node 0, two beats
    clear_logs();
    bank_pkt[3].req = 1'b1;
    wait_grant("t8", gb);
    check_eq("t8_grant_vec", 32'(req_grant), 32'b1000);
    send_stream(2'd3, 0, 2, 1'b1, 1'b0);
    settle(4);
    exp_q.push_back({10'd0, 16'h0101});
    exp_q.push_back({10'd1, 16'h0202});
    compare_writes("t8");
    check_eq("t8_ndone", 32'(done_q.size()), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
